// File: rtl/detect_pkg.sv
// detect_pkg: shared state encodings and pattern constants for the 1,1,0,1,0 sequencer
package detect_pkg;
  localparam int PAT_LEN = 5;
  localparam logic [2:0] S0 = 3'd0;
  localparam logic [2:0] S1 = 3'd1;
  localparam logic [2:0] S2 = 3'd2;
  localparam logic [2:0] S3 = 3'd3;
  localparam logic [2:0] S4 = 3'd4;
  localparam logic [2:0] S5 = 3'd5;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] REPORT = 2'd2;
endpackage

// File: rtl/seq_detect_core.sv
// seq_detect_core: Moore detector for serial 1,1,0,1,0; sticky once matched, cleared while disabled
module seq_detect_core
  import detect_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic d_i,
  output logic detect_o
);
  logic [2:0] st_q, st_d;
  always_comb begin
    st_d = !en_i     ? S0 :
           st_q == S0 ? (d_i ? S1 : S0) :
           st_q == S1 ? (d_i ? S2 : S0) :
           st_q == S2 ? (d_i ? S2 : S3) :
           st_q == S3 ? (d_i ? S4 : S0) :
           st_q == S4 ? (d_i ? S2 : S5) :
           st_q == S5 ? S5 : S0;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) st_q <= S0;
    else       st_q <= st_d;
  end
  assign detect_o = st_q == S5;
endmodule

// File: rtl/detect_sequencer.sv
// detect_sequencer: scans accepted words MSB first for 1,1,0,1,0 and reports the first match position
module detect_sequencer
  import detect_pkg::*;
#(
  parameter  int DATA_W = 16,
  parameter  int CNT_W  = 8,
  localparam int LW     = $clog2(DATA_W) + 1,
  localparam int PW     = $clog2(DATA_W)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              word_valid_i,
  input  logic [DATA_W-1:0] word_i,
  input  logic [LW-1:0]     len_i,
  input  logic              abort_i,
  output logic              word_ready_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              hit_o,
  output logic [PW-1:0]     hit_pos_o,
  output logic [CNT_W-1:0]  hit_cnt_o
);
  logic [1:0]        st_q, st_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [LW-1:0]     len_q, len_d, bit_q, bit_d, len_eff;
  logic              flag_q, flag_d, hit_q, hit_d;
  logic [PW-1:0]     fpos_q, fpos_d, pos_q, pos_d, pos_now;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              det, en, accept, rep, hit_now;
  assign accept  = st_q == IDLE && word_valid_i;
  assign rep     = st_q == REPORT;
  assign en      = st_q == SHIFT && !abort_i;
  assign len_eff = (len_i == '0 || len_i > LW'(DATA_W)) ? LW'(DATA_W) : len_i;
  // the detector is still sticky in REPORT, so a final-bit match shows up here
  assign hit_now = flag_q | det;
  assign pos_now = flag_q ? fpos_q : det ? PW'(len_q - 1'b1) : '0;
  seq_detect_core u_core (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (en),
    .d_i      (sr_q[DATA_W-1]),
    .detect_o (det)
  );
  always_comb begin
    st_d   = st_q;
    sr_d   = sr_q;
    len_d  = len_q;
    bit_d  = bit_q;
    flag_d = flag_q;
    fpos_d = fpos_q;
    hit_d  = hit_q;
    pos_d  = pos_q;
    cnt_d  = cnt_q;
    if (accept) begin
      st_d   = SHIFT;
      sr_d   = word_i;
      len_d  = len_eff;
      bit_d  = '0;
      flag_d = 1'b0;
      fpos_d = '0;
    end else if (st_q == SHIFT) begin
      if (abort_i) begin
        st_d = IDLE;
      end else begin
        sr_d  = sr_q << 1;
        bit_d = bit_q + 1'b1;
        if (bit_q != '0 && det) begin
          st_d   = REPORT;
          flag_d = 1'b1;
          fpos_d = PW'(bit_q - 1'b1);
        end else if (bit_q == len_q - 1'b1) begin
          st_d = REPORT;
        end
      end
    end else if (rep) begin
      st_d  = IDLE;
      hit_d = hit_now;
      pos_d = pos_now;
      cnt_d = (hit_now && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st_q   <= IDLE;
      sr_q   <= '0;
      len_q  <= '0;
      bit_q  <= '0;
      flag_q <= 1'b0;
      fpos_q <= '0;
      hit_q  <= 1'b0;
      pos_q  <= '0;
      cnt_q  <= '0;
    end else begin
      st_q   <= st_d;
      sr_q   <= sr_d;
      len_q  <= len_d;
      bit_q  <= bit_d;
      flag_q <= flag_d;
      fpos_q <= fpos_d;
      hit_q  <= hit_d;
      pos_q  <= pos_d;
      cnt_q  <= cnt_d;
    end
  end
  assign word_ready_o = st_q == IDLE;
  assign busy_o       = st_q == SHIFT || rep;
  assign done_o       = rep;
  assign hit_o        = rep ? hit_now : hit_q;
  assign hit_pos_o    = rep ? pos_now : pos_q;
  assign hit_cnt_o    = cnt_q;
endmodule

// File: tb/tb_detect_sequencer.sv
// tb_detect_sequencer: scoreboard bench; a substring-search model predicts hit, position and done cycle
module tb_detect_sequencer;
  logic        clk_i = 0, rst_i = 1, word_valid_i = 0, abort_i = 0;
  logic [15:0] word_i = '0;
  logic [4:0]  len_i = '0;
  logic        word_ready_o, busy_o, done_o, hit_o;
  logic [3:0]  hit_pos_o;
  logic [7:0]  hit_cnt_o;
  detect_sequencer dut (
    .clk_i(clk_i), .rst_i(rst_i), .word_valid_i(word_valid_i), .word_i(word_i),
    .len_i(len_i), .abort_i(abort_i), .word_ready_o(word_ready_o), .busy_o(busy_o),
    .done_o(done_o), .hit_o(hit_o), .hit_pos_o(hit_pos_o), .hit_cnt_o(hit_cnt_o)
  );
  always #5 clk_i = ~clk_i;
  typedef struct {logic hit; logic [3:0] pos; int cyc;} exp_t;
  exp_t sbq[$];
  int cyc = 0, total = 0, bad = 0, exp_cnt = 0;
  always @(posedge clk_i) cyc++;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask
  function automatic exp_t model(logic [15:0] w, logic [4:0] l, int acc);
    exp_t e;
    int n = (l == 0 || l > 16) ? 16 : int'(l);
    e.hit = 0; e.pos = 0; e.cyc = acc + n + 1;
    for (int i = 4; i < n; i++)
      if (!e.hit && w[19-i -: 5] == 5'b11010) begin
        e.hit = 1; e.pos = 4'(i);
        e.cyc = (i < n - 1) ? acc + i + 3 : acc + n + 1;
      end
    return e;
  endfunction
  always @(negedge clk_i) begin
    if (rst_i) exp_cnt = 0;
    else if (done_o) begin
      exp_t e;
      if (sbq.size() == 0) chk("spurious_done", 1, 0);
      else begin
        e = sbq.pop_front();
        chk("hit", hit_o, e.hit);
        chk("pos", hit_pos_o, e.pos);
        chk("done_cycle", cyc, e.cyc);
        chk("cnt_at_done", hit_cnt_o, exp_cnt);
        if (e.hit && exp_cnt < 255) exp_cnt++;
      end
    end
  end
  task automatic submit(logic [15:0] w, logic [4:0] l, bit push);
    int n = 0;
    while (!word_ready_o && n < 100) begin @(posedge clk_i); #1; n++; end
    if (!word_ready_o) chk("ready_timeout", 0, 1);
    word_valid_i = 1; word_i = w; len_i = l;
    if (push) sbq.push_back(model(w, l, cyc));
    @(posedge clk_i); #1;
    word_valid_i = 0;
  endtask
  task automatic drain();
    int n = 0;
    while ((sbq.size() > 0 || !word_ready_o) && n < 200) begin @(posedge clk_i); #1; n++; end
    if (sbq.size() > 0) begin
      chk("drain_timeout", sbq.size(), 0);
      sbq.delete();
    end
  endtask
  initial begin
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_ready", word_ready_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_hit", hit_o, 0);
    chk("rst_cnt", hit_cnt_o, 0);
    rst_i = 0;
    @(posedge clk_i); #1;
    submit(16'hD000, 5'd0, 1);
    drain();
    chk("cnt_first", hit_cnt_o, 1);
    submit(16'hF400, 5'd16, 1);
    submit(16'hD000, 5'd5, 1);
    submit(16'hD000, 5'd3, 1);
    submit(16'hFFFF, 5'd16, 1);
    drain();
    chk("cnt_after_miss", hit_cnt_o, 3);
    submit(16'hFFFF, 5'd16, 0);
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    abort_i = 1;
    @(posedge clk_i); #1;
    abort_i = 0;
    chk("abort_ready", word_ready_o, 1);
    chk("abort_busy", busy_o, 0);
    chk("abort_hit_held", hit_o, 0);
    abort_i = 1;
    submit(16'hD000, 5'd0, 1);
    abort_i = 0;
    drain();
    for (int i = 0; i < 25; i++) submit(16'($urandom), 5'($urandom_range(0, 31)), 1);
    drain();
    repeat (300) submit(16'hD000, 5'd5, 1);
    drain();
    chk("cnt_saturated", hit_cnt_o, 255);
    submit(16'hD000, 5'd0, 0);
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    rst_i = 1;
    #1;
    chk("mid_rst_ready", word_ready_o, 1);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_done", done_o, 0);
    chk("mid_rst_hit", hit_o, 0);
    chk("mid_rst_pos", hit_pos_o, 0);
    chk("mid_rst_cnt", hit_cnt_o, 0);
    @(posedge clk_i); #1;
    rst_i = 0;
    @(posedge clk_i); #1;
    submit(16'hD000, 5'd0, 1);
    drain();
    chk("cnt_after_rst", hit_cnt_o, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
